// File: rtl/qa_rcc_pkg.sv
// Shared mode encoding for the reset/clock-enable controller.
package qa_rcc_pkg;

    typedef enum logic [1:0] {
        QA_MODE_HALT = 2'b00,
        QA_MODE_STEP = 2'b01,
        QA_MODE_DIV  = 2'b10,
        QA_MODE_FULL = 2'b11
    } qa_rcc_mode_t;

endpackage

// File: rtl/qa_debounce.sv
// Button filter: 2-FF synchroniser, then the level only follows after DEB_CYCLES equal samples.
// Idle (released) level is 1; the output lags the pin by 2+DEB_CYCLES cycles.
module qa_debounce #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o
);
    localparam int CW = $clog2(DEB_CYCLES);

    logic          sync0_q, sync1_q, level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync1_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = sync1_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= 1'b1;
            sync1_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync0_q <= btn_i;
            sync1_q <= sync0_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/qa_rcc_gen2.sv
// Reset synchroniser/stretcher plus CPU clock-enable strobe generator (HALT/STEP/DIV/FULL).
// Mode inputs are registered; the strobe is registered again, so it trails the registered mode by one cycle.
module qa_rcc_gen2
    import qa_rcc_pkg::*;
#(
    parameter int CNT_W        = 24,
    parameter int DIV_SEL_W    = 4,
    parameter int MIN_DIV_LOG2 = 4,
    parameter int RST_HOLD     = 16,
    parameter int DEB_CYCLES   = 1000
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 ClockManual,
    input  logic [1:0]           ModeSelect,
    input  logic [DIV_SEL_W-1:0] DivSelect,
    output logic                 ClockEnable,
    output logic                 ClockMain,
    output logic                 ResetMain,
    output logic                 StepPending
);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    logic                 rsync0_q, rsync1_q, rst_q;
    logic [HOLD_W-1:0]    hold_q;
    qa_rcc_mode_t         mode_q, mode_in;
    logic [DIV_SEL_W-1:0] div_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d, div_mask;
    logic                 btn_lvl, btn_lvl_q, press, div_clr;
    logic                 strobe, ce_q, ce_d, clk_main_q, clk_main_d;

    qa_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_btn (
        .clk     (Clock),
        .rst_n   (nReset),
        .btn_i   (ClockManual),
        .level_o (btn_lvl)
    );

    // Exponent saturates naturally: bits at or above CNT_W simply do not exist.
    always_comb begin
        div_mask = '0;
        for (int i = 0; i < CNT_W; i++) begin
            if (i < MIN_DIV_LOG2 + int'(div_q)) div_mask[i] = 1'b1;
        end
    end

    always_comb begin
        mode_in = qa_rcc_mode_t'(ModeSelect);
        div_clr = (mode_in == QA_MODE_DIV) && ((mode_q != QA_MODE_DIV) || (DivSelect != div_q));
        press   = btn_lvl_q & ~btn_lvl;
        cnt_d   = cnt_q + 1'b1;
        if (rst_q || div_clr || (mode_q != QA_MODE_DIV)) cnt_d = '0;
        case (mode_q)
            QA_MODE_STEP: strobe = press;
            QA_MODE_DIV:  strobe = ((cnt_q & div_mask) == div_mask);
            QA_MODE_FULL: strobe = 1'b1;
            default:      strobe = 1'b0;
        endcase
        ce_d       = strobe & ~rst_q;
        clk_main_d = clk_main_q ^ ce_q;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rsync0_q   <= 1'b0;
            rsync1_q   <= 1'b0;
            rst_q      <= 1'b1;
            hold_q     <= '0;
            mode_q     <= QA_MODE_HALT;
            div_q      <= '0;
            cnt_q      <= '0;
            btn_lvl_q  <= 1'b1;
            ce_q       <= 1'b0;
            clk_main_q <= 1'b0;
        end else begin
            rsync0_q <= 1'b1;
            rsync1_q <= rsync0_q;
            if (rsync1_q && rst_q) begin
                hold_q <= hold_q + 1'b1;
                if (hold_q == HOLD_W'(RST_HOLD - 1)) rst_q <= 1'b0;
            end
            mode_q     <= mode_in;
            div_q      <= DivSelect;
            cnt_q      <= cnt_d;
            btn_lvl_q  <= btn_lvl;
            ce_q       <= ce_d;
            clk_main_q <= clk_main_d;
        end
    end

    assign ClockEnable = ce_q;
    assign ClockMain   = clk_main_q;
    assign ResetMain   = rst_q;
    assign StepPending = ~btn_lvl;

endmodule

// File: tb/tb_qa_rcc_gen2.sv
// Scoreboard bench: stimulus predicts strobe cycles into a queue, a negedge monitor checks every cycle.
module tb_qa_rcc_gen2;
    import qa_rcc_pkg::*;

    localparam int DEB  = 8;
    localparam int HOLD = 16;
    localparam int MINL = 4;

    logic       Clock = 1'b0;
    logic       nReset = 1'b0;
    logic       ClockManual = 1'b1;
    logic [1:0] ModeSelect = 2'b00;
    logic [3:0] DivSelect = 4'd0;
    logic       ClockEnable, ClockMain, ResetMain, StepPending;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_q[$];
    bit cm_exp = 1'b0;
    bit tog_pend = 1'b0;

    qa_rcc_gen2 #(
        .CNT_W(24), .DIV_SEL_W(4), .MIN_DIV_LOG2(MINL), .RST_HOLD(HOLD), .DEB_CYCLES(DEB)
    ) dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .ClockManual (ClockManual),
        .ModeSelect  (ModeSelect),
        .DivSelect   (DivSelect),
        .ClockEnable (ClockEnable),
        .ClockMain   (ClockMain),
        .ResetMain   (ResetMain),
        .StepPending (StepPending)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Expected strobe cycles are those after edge e, every p cycles, up to and including edge f.
    task automatic push_period(int e, int f, int p);
        for (int t = e + p; t <= f; t += p) exp_q.push_back(t);
    endtask

    task automatic step(int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic step_to(int t);
        while (cyc < t) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic neg_at(int t);
        do @(negedge Clock); while (cyc < t);
    endtask

    always @(negedge Clock) begin
        bit exp_ce;
        if (!nReset) begin
            cm_exp   = 1'b0;
            tog_pend = 1'b0;
        end else if (tog_pend) begin
            cm_exp   = ~cm_exp;
            tog_pend = 1'b0;
        end
        check("clock_main", ClockMain, cm_exp);
        exp_ce = (exp_q.size() > 0) && (exp_q[0] == cyc);
        check("clock_enable", ClockEnable, exp_ce);
        if (exp_ce) begin
            void'(exp_q.pop_front());
            tog_pend = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, r2, e, f, g, h, n, sel, len;

        // Reset state and release timing
        step(5);
        @(negedge Clock);
        check("rst_resetmain", ResetMain, 1);
        check("rst_steppending", StepPending, 0);
        check("rst_clockmain", ClockMain, 0);
        check("rst_clockenable", ClockEnable, 0);
        step(1);
        nReset = 1'b1;
        r = cyc;
        neg_at(r + 2 + HOLD - 1);
        check("hold_before_fall", ResetMain, 1);
        neg_at(r + 2 + HOLD);
        check("hold_fall", ResetMain, 0);

        // Reset pulse in the middle of the hold restarts the sequence
        step(1);
        nReset = 1'b0;
        step(5);
        nReset = 1'b1;
        r = cyc;
        neg_at(r + 8);
        check("midhold_before", ResetMain, 1);
        step(1);
        nReset = 1'b0;
        step(2);
        check("midhold_async", ResetMain, 1);
        nReset = 1'b1;
        r2 = cyc;
        neg_at(r2 + 2 + HOLD - 1);
        check("midhold_restart_hi", ResetMain, 1);
        neg_at(r2 + 2 + HOLD);
        check("midhold_restart_lo", ResetMain, 0);

        // DIV: DivSelect 0 then 2 then a random other exponent
        step(3);
        DivSelect  = 4'd0;
        ModeSelect = QA_MODE_DIV;
        e = cyc + 1;
        f = e + 40 + int'($urandom_range(0, 40));
        push_period(e, f, 1 << MINL);
        step_to(f - 1);
        DivSelect = 4'd2;
        g = f + 3 * 64 + int'($urandom_range(0, 50));
        push_period(f, g, 1 << (MINL + 2));
        step_to(g - 1);
        sel = int'($urandom_range(0, 2));
        if (sel == 2) sel = 3;
        DivSelect = 4'(sel);
        h = g + 3 * (1 << (MINL + sel)) + int'($urandom_range(0, 20));
        push_period(g, h, 1 << (MINL + sel));
        step_to(h - 1);
        ModeSelect = QA_MODE_HALT;
        step(20);
        check("div_queue_drained", exp_q.size(), 0);

        // STEP with a bouncing button, then held low
        ModeSelect = QA_MODE_STEP;
        step(3);
        for (int b = 0; b < 3; b++) begin
            ClockManual = 1'b0;
            step(int'($urandom_range(1, 2)));
            ClockManual = 1'b1;
            step(int'($urandom_range(1, 2)));
        end
        ClockManual = 1'b0;
        n = cyc;
        exp_q.push_back(n + 2 + DEB + 1);
        neg_at(n + 2 + DEB - 1);
        check("step_pending_early", StepPending, 0);
        neg_at(n + 2 + DEB);
        check("step_pending_set", StepPending, 1);
        step_to(n + 40);
        ClockManual = 1'b1;
        r = cyc;
        neg_at(r + 2 + DEB);
        check("step_pending_clear", StepPending, 0);
        step(1);

        // Press in DIV, switch to STEP while held: nothing; re-press gives one pulse
        DivSelect  = 4'd15;
        ModeSelect = QA_MODE_DIV;
        step(3);
        ClockManual = 1'b0;
        step(20);
        ModeSelect = QA_MODE_STEP;
        step(20);
        check("held_pending", StepPending, 1);
        ClockManual = 1'b1;
        step(20);
        ClockManual = 1'b0;
        n = cyc;
        exp_q.push_back(n + 2 + DEB + 1);
        step(25);
        ClockManual = 1'b1;
        step(20);

        // FULL for 10 cycles, then HALT; repeated with random burst lengths
        ModeSelect = QA_MODE_FULL;
        e = cyc + 1;
        push_period(e, e + 10, 1);
        step(10);
        ModeSelect = QA_MODE_HALT;
        step(20);
        for (int k = 0; k < 4; k++) begin
            len = int'($urandom_range(1, 9));
            ModeSelect = QA_MODE_FULL;
            e = cyc + 1;
            push_period(e, e + len, 1);
            step(len);
            ModeSelect = QA_MODE_HALT;
            step(int'($urandom_range(3, 12)));
        end

        step(5);
        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
